// File: rtl/mux2x1.sv
`timescale 1ns/1ps
`default_nettype none
// mux2x1: N-bit two-input selector with select tracking (sel_q, sel_toggle, saturating toggle_count).
// Optional output register enabled by defining MUX2X1_OUTREG_EN.
module mux2x1 #(
  parameter int N = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*N-1:0] in,
  input  logic           sel,
  output logic [N-1:0]   out,
  output logic           sel_q,
  output logic           sel_toggle,
  output logic [15:0]    toggle_count
);

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic [N-1:0] in0;
  logic [N-1:0] in1;
  logic [N-1:0] sel_mask;
  logic [N-1:0] sel_word;
  logic         changed;

  assign in0      = in[N-1:0];
  assign in1      = in[2*N-1:N];
  assign sel_mask = {N{sel}};

  // The consensus term keeps bits that agree in both inputs defined under an unknown select.
  assign sel_word = (in0 & ~sel_mask) | (in1 & sel_mask) | (in0 & in1);

  assign changed = sel ^ sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q        <= 1'b0;
      sel_toggle   <= 1'b0;
      toggle_count <= 16'd0;
    end else begin
      sel_q      <= sel;
      sel_toggle <= changed;
      if (changed && (toggle_count != COUNT_MAX))
        toggle_count <= toggle_count + 16'd1;
    end
  end

`ifdef MUX2X1_OUTREG_EN
  always_ff @(posedge clk) begin
    if (rst)
      out <= '0;
    else
      out <= sel_word;
  end
`else
  assign out = sel_word;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux2x1.sv
`timescale 1ns/1ps
`default_nettype none
// tb_mux2x1: table vectors, directed tracking sequences and random stimulus against a reference model.
module tb_mux2x1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sel = 1'b0;
  logic [1:0]   in1 = '0;
  logic [15:0]  in8 = '0;
  logic [127:0] in64 = '0;
  logic [0:0]   out1;
  logic [7:0]   out8;
  logic [63:0]  out64;
  logic         q1, t1, q8, t8, q64, t64;
  logic [15:0]  c1, c8, c64;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_q = 0;
  int          m_t = 0;
  int          m_cnt = 0;
  logic [63:0] m_o1 = '0, m_o8 = '0, m_o64 = '0;
  bit          m_o_valid = 0;

  always #5 clk = ~clk;

  mux2x1 #(.N(1)) u_n1 (
    .clk(clk), .rst(rst), .in(in1), .sel(sel), .out(out1),
    .sel_q(q1), .sel_toggle(t1), .toggle_count(c1)
  );
  mux2x1 #(.N(8)) u_n8 (
    .clk(clk), .rst(rst), .in(in8), .sel(sel), .out(out8),
    .sel_q(q8), .sel_toggle(t8), .toggle_count(c8)
  );
  mux2x1 #(.N(64)) u_n64 (
    .clk(clk), .rst(rst), .in(in64), .sel(sel), .out(out64),
    .sel_q(q64), .sel_toggle(t64), .toggle_count(c64)
  );

  function automatic logic [63:0] pick(input logic [127:0] bus, input int n, input logic s);
    logic [127:0] sh;
    logic [63:0]  mask;
    sh   = bus >> (s ? n : 0);
    mask = (64'h1 << n) - 64'h1;
    return sh[63:0] & mask;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input logic [127:0] bus, input logic s, input logic r);
    in1  = bus[1:0];
    in8  = bus[15:0];
    in64 = bus;
    sel  = s;
    rst  = r;
    #1;
`ifndef MUX2X1_OUTREG_EN
    chk("comb_out_n1",  64'(out1),  pick(bus, 1, s));
    chk("comb_out_n8",  64'(out8),  pick(bus, 8, s));
    chk("comb_out_n64", out64,      pick(bus, 64, s));
`else
    if (m_o_valid) begin
      chk("reg_hold_n1",  64'(out1),  m_o1);
      chk("reg_hold_n8",  64'(out8),  m_o8);
      chk("reg_hold_n64", out64,      m_o64);
    end
`endif
    @(posedge clk);
    #1;
    if (r) begin
      m_q = 0; m_t = 0; m_cnt = 0;
    end else begin
      m_t = (int'(s) != m_q) ? 1 : 0;
      m_q = int'(s);
      if (m_t == 1 && m_cnt < 65535) m_cnt++;
    end
    chk("sel_q_n1", 64'(q1), 64'(m_q));
    chk("sel_q_n8", 64'(q8), 64'(m_q));
    chk("sel_q_n64", 64'(q64), 64'(m_q));
    chk("toggle_n1", 64'(t1), 64'(m_t));
    chk("toggle_n8", 64'(t8), 64'(m_t));
    chk("toggle_n64", 64'(t64), 64'(m_t));
    chk("count_n1", 64'(c1), 64'(m_cnt));
    chk("count_n8", 64'(c8), 64'(m_cnt));
    chk("count_n64", 64'(c64), 64'(m_cnt));
`ifdef MUX2X1_OUTREG_EN
    m_o1  = r ? 64'd0 : pick(bus, 1, s);
    m_o8  = r ? 64'd0 : pick(bus, 8, s);
    m_o64 = r ? 64'd0 : pick(bus, 64, s);
    m_o_valid = 1;
    chk("reg_out_n1",  64'(out1),  m_o1);
    chk("reg_out_n8",  64'(out8),  m_o8);
    chk("reg_out_n64", out64,      m_o64);
`endif
  endtask

  typedef struct {
    string        name;
    int           n;
    logic [127:0] bus;
    logic         s;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs[7];
  logic [63:0] act;
  int          exp_tog[4];
  logic        seq_sel[4];

  initial begin
    vecs[0] = '{"tt_00_s0", 1,  128'b00, 1'b0, 64'd0};
    vecs[1] = '{"tt_01_s0", 1,  128'b01, 1'b0, 64'd1};
    vecs[2] = '{"tt_00_s1", 1,  128'b00, 1'b1, 64'd0};
    vecs[3] = '{"tt_10_s1", 1,  128'b10, 1'b1, 64'd1};
    vecs[4] = '{"wide_s0", 64, {64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF}, 1'b0,
                64'h0123_4567_89AB_CDEF};
    vecs[5] = '{"wide_s1", 64, {64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF}, 1'b1,
                64'hFFFF_0000_FFFF_0000};
    vecs[6] = '{"byte_s1", 8,  {112'd0, 8'hA5, 8'h3C}, 1'b1, 64'h0000_0000_0000_00A5};

    // Reset for two cycles
    drive_cycle('0, 1'b0, 1'b1);
    drive_cycle('0, 1'b0, 1'b1);
    chk("reset_sel_q", 64'(q8), 64'd0);
    chk("reset_count", 64'(c8), 64'd0);
    chk("reset_toggle", 64'(t8), 64'd0);
`ifdef MUX2X1_OUTREG_EN
    chk("reset_out", 64'(out8), 64'd0);
`endif

    // Truth-table and wide vectors
    for (int i = 0; i < 7; i++) begin
      drive_cycle(vecs[i].bus, vecs[i].s, 1'b0);
      case (vecs[i].n)
        1:       act = 64'(out1);
        8:       act = 64'(out8);
        default: act = out64;
      endcase
      chk(vecs[i].name, act, vecs[i].exp);
    end

    // Tracking sequence 1,1,0,1 after reset
    drive_cycle('0, 1'b0, 1'b1);
    drive_cycle('0, 1'b0, 1'b1);
    seq_sel = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_tog = '{1, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(128'(i), seq_sel[i], 1'b0);
      chk("seq_toggle", 64'(t8), 64'(exp_tog[i]));
    end
    chk("seq_count", 64'(c8), 64'd3);

    // Reset mid-operation with count at 5
    drive_cycle('0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive_cycle('1, (i % 2 == 0), 1'b0);
    chk("mid_count5", 64'(c8), 64'd5);
    drive_cycle('1, 1'b1, 1'b1);
    chk("mid_rst_q", 64'(q8), 64'd0);
    chk("mid_rst_toggle", 64'(t8), 64'd0);
    chk("mid_rst_count", 64'(c8), 64'd0);
`ifdef MUX2X1_OUTREG_EN
    chk("mid_rst_out", 64'(out8), 64'd0);
`endif
    drive_cycle('1, 1'b0, 1'b0);
    drive_cycle('1, 1'b1, 1'b0);
    chk("resume_count", 64'(c8), 64'd1);

    // Random stimulus
    for (int i = 0; i < 300; i++) begin
      drive_cycle({$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
                  ($urandom_range(0, 19) == 0));
    end

    // Saturation: alternate select long enough to overflow 16 bits
    drive_cycle('0, 1'b0, 1'b1);
    for (int i = 0; i < 65540; i++) drive_cycle(128'(i), (i % 2 == 0), 1'b0);
    chk("sat_count", 64'(c8), 64'hFFFF);
    chk("sat_toggle", 64'(t8), 64'd1);
    drive_cycle('0, 1'b0, 1'b0);
    chk("sat_hold", 64'(c64), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
